// File: rtl/imm_decode_ctrl_if.sv
// Fetch-side and ID/EX-side handshake bundle for the decode-stage immediate controller.
interface imm_decode_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    // fetch -> decode
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic                  instr_ready;

    // decode -> execute
    logic                  ex_ready;
    logic                  id_valid;
    logic [DATA_WIDTH-1:0] id_imm;
    logic [DATA_WIDTH-1:0] id_pc;
    logic [4:0]            id_rd;
    logic                  id_illegal;

    modport master (
        output instr_valid,
        output instr,
        output pc,
        output ex_ready,
        input  instr_ready,
        input  id_valid,
        input  id_imm,
        input  id_pc,
        input  id_rd,
        input  id_illegal
    );

    modport slave (
        input  instr_valid,
        input  instr,
        input  pc,
        input  ex_ready,
        output instr_ready,
        output id_valid,
        output id_imm,
        output id_pc,
        output id_rd,
        output id_illegal
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode-stage immediate controller: opcode -> ImmSrc, one-entry ID/EX holding register, trap FSM.
// Optional DECODE_PERF_EN adds perf_accept / perf_stall counters.
module imm_decode_ctrl #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    imm_decode_ctrl_if.slave      bus,
    input  logic                  flush,
    output logic [2:0]            ImmSrc,
    output logic [DATA_WIDTH-8:0] Imm_i,
    input  logic [DATA_WIDTH-1:0] Imm_o
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]           perf_accept,
    output logic [31:0]           perf_stall
`endif
);

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] SrcI = 3'b000;
    localparam logic [2:0] SrcU = 3'b001;
    localparam logic [2:0] SrcS = 3'b010;
    localparam logic [2:0] SrcB = 3'b011;
    localparam logic [2:0] SrcJ = 3'b100;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StTrap
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] id_imm_q, id_pc_q;
    logic [4:0]            id_rd_q;
    logic                  id_illegal_q;

    logic       imm_zero;
    logic       rd_zero;
    logic       illegal;
    logic       accept;
    logic       ready;
    logic [6:0] opcode;

    assign opcode = bus.instr[6:0];

    // Opcode decode; R-type and unknown opcodes carry no immediate.
    always_comb begin
        ImmSrc   = SrcI;
        imm_zero = 1'b0;
        rd_zero  = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OpImm, OpLoad, OpJalr: ImmSrc = SrcI;
            OpLui, OpAuipc:        ImmSrc = SrcU;
            OpStore: begin
                ImmSrc  = SrcS;
                rd_zero = 1'b1;
            end
            OpBranch: begin
                ImmSrc  = SrcB;
                rd_zero = 1'b1;
            end
            OpJal:                 ImmSrc = SrcJ;
            OpReg:                 imm_zero = 1'b1;
            default: begin
                imm_zero = 1'b1;
                illegal  = 1'b1;
            end
        endcase
    end

    assign Imm_i = bus.instr_valid ? bus.instr[DATA_WIDTH-1:7] : '0;

    assign accept = bus.instr_valid & ready;

    // Next-state and handshake outputs; flush overrides every other transition.
    always_comb begin
        state_d      = state_q;
        ready        = 1'b0;
        bus.id_valid = (state_q == StHold);
        if (!rst_n) begin
            state_d = StIdle;
        end else if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    ready = 1'b1;
                    if (bus.instr_valid) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    // An illegal entry leaving the register freezes decode instead of refilling.
                    ready = bus.ex_ready & ~id_illegal_q;
                    if (bus.ex_ready) begin
                        if (id_illegal_q) begin
                            state_d = StTrap;
                        end else if (bus.instr_valid) begin
                            state_d = StHold;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StTrap: begin
                    state_d = StTrap;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.instr_ready = ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            id_imm_q     <= '0;
            id_pc_q      <= '0;
            id_rd_q      <= '0;
            id_illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_imm_q     <= imm_zero ? '0 : Imm_o;
                id_pc_q      <= bus.pc;
                id_rd_q      <= rd_zero ? 5'd0 : bus.instr[11:7];
                id_illegal_q <= illegal;
            end
        end
    end

    assign bus.id_imm     = id_imm_q;
    assign bus.id_pc      = id_pc_q;
    assign bus.id_rd      = id_rd_q;
    assign bus.id_illegal = id_illegal_q;

`ifdef DECODE_PERF_EN
    logic [31:0] perf_accept_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_accept_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (accept) begin
                perf_accept_q <= perf_accept_q + 32'd1;
            end
            if (bus.instr_valid && !ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_accept = perf_accept_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Directed bench for imm_decode_ctrl with a behavioural SignExtend model on the Imm_i/Imm_o loop.
module tb_imm_decode_ctrl;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [2:0]  ImmSrc;
    logic [24:0] Imm_i;
    logic [31:0] Imm_o;
`ifdef DECODE_PERF_EN
    logic [31:0] perf_accept;
    logic [31:0] perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    imm_decode_ctrl_if #(.DATA_WIDTH(32)) bus ();

    imm_decode_ctrl #(.DATA_WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .flush  (flush),
        .ImmSrc (ImmSrc),
        .Imm_i  (Imm_i),
        .Imm_o  (Imm_o)
`ifdef DECODE_PERF_EN
        ,
        .perf_accept (perf_accept),
        .perf_stall  (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Imm_i[k] carries instr[k+7].
    function automatic logic [31:0] sext(input logic [2:0] src, input logic [24:0] i);
        case (src)
            3'b000:  sext = {{20{i[24]}}, i[24:13]};
            3'b001:  sext = {i[24:5], 12'b0};
            3'b010:  sext = {{20{i[24]}}, i[24:18], i[4:0]};
            3'b011:  sext = {{19{i[24]}}, i[24], i[0], i[23:18], i[4:1], 1'b0};
            3'b100:  sext = {{11{i[24]}}, i[24], i[12:5], i[13], i[23:14], 1'b0};
            default: sext = 32'h0;
        endcase
    endfunction

    assign Imm_o = sext(ImmSrc, Imm_i);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
        bus.instr_valid = v;
        bus.instr       = ins;
        bus.pc          = p;
    endtask

    localparam logic [31:0] IAddi = 32'hFFF0_0093;
    localparam logic [31:0] ILui  = 32'h1234_50B7;
    localparam logic [31:0] ISw   = 32'hFE11_2E23;
    localparam logic [31:0] IBeq  = 32'h0020_8463;
    localparam logic [31:0] IJal  = 32'h0080_00EF;
    localparam logic [31:0] IAdd  = 32'h0020_81B3;
    localparam logic [31:0] IBad  = 32'h0000_007F;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);

        // Reset
        #1;
        check_eq("ready_in_reset", {31'b0, bus.instr_ready}, 32'd0);
        tick();
        tick();
        check_eq("rst_valid", {31'b0, bus.id_valid}, 32'd0);
        check_eq("rst_imm", bus.id_imm, 32'h0);
        check_eq("rst_pc", bus.id_pc, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("idle_ready", {31'b0, bus.instr_ready}, 32'd1);

        // addi x1,x0,-1
        drive(1'b1, IAddi, 32'h100);
        #1;
        check_eq("addi_src", {29'b0, ImmSrc}, 32'd0);
        check_eq("addi_immi", {7'b0, Imm_i}, 32'h01FF_E001);
        tick();
        check_eq("addi_valid", {31'b0, bus.id_valid}, 32'd1);
        check_eq("addi_imm", bus.id_imm, 32'hFFFF_FFFF);
        check_eq("addi_rd", {27'b0, bus.id_rd}, 32'd1);
        check_eq("addi_pc", bus.id_pc, 32'h100);
        check_eq("addi_ill", {31'b0, bus.id_illegal}, 32'd0);

        // lui then sw back-to-back
        drive(1'b1, ILui, 32'h104);
        #1;
        check_eq("b2b_ready", {31'b0, bus.instr_ready}, 32'd1);
        check_eq("lui_src", {29'b0, ImmSrc}, 32'd1);
        tick();
        check_eq("lui_imm", bus.id_imm, 32'h1234_5000);
        check_eq("lui_rd", {27'b0, bus.id_rd}, 32'd1);
        drive(1'b1, ISw, 32'h108);
        #1;
        check_eq("sw_src", {29'b0, ImmSrc}, 32'd2);
        tick();
        check_eq("sw_imm", bus.id_imm, 32'hFFFF_FFFC);
        check_eq("sw_rd", {27'b0, bus.id_rd}, 32'd0);
        check_eq("sw_pc", bus.id_pc, 32'h108);

        // beq captured, then 3 stall cycles with jal waiting
        drive(1'b1, IBeq, 32'h10C);
        #1;
        check_eq("beq_src", {29'b0, ImmSrc}, 32'd3);
        tick();
        check_eq("beq_imm", bus.id_imm, 32'h0000_0008);
        bus.ex_ready = 1'b0;
        drive(1'b1, IJal, 32'h110);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("stall_ready", {31'b0, bus.instr_ready}, 32'd0);
            tick();
            check_eq("stall_valid", {31'b0, bus.id_valid}, 32'd1);
            check_eq("stall_imm", bus.id_imm, 32'h0000_0008);
            check_eq("stall_pc", bus.id_pc, 32'h10C);
            check_eq("stall_rd", {27'b0, bus.id_rd}, 32'd0);
        end
`ifdef DECODE_PERF_EN
        check_eq("perf_stall", perf_stall, 32'd3);
        check_eq("perf_accept", perf_accept, 32'd4);
`endif

        // Release: jal accepted
        bus.ex_ready = 1'b1;
        #1;
        check_eq("release_ready", {31'b0, bus.instr_ready}, 32'd1);
        check_eq("jal_src", {29'b0, ImmSrc}, 32'd4);
        tick();
        check_eq("jal_imm", bus.id_imm, 32'h0000_0008);
        check_eq("jal_rd", {27'b0, bus.id_rd}, 32'd1);
        check_eq("jal_pc", bus.id_pc, 32'h110);

        // R-type: immediate forced to zero
        drive(1'b1, IAdd, 32'h114);
        tick();
        check_eq("add_imm", bus.id_imm, 32'h0);
        check_eq("add_rd", {27'b0, bus.id_rd}, 32'd3);
        check_eq("add_ill", {31'b0, bus.id_illegal}, 32'd0);

        // Illegal opcode -> one cycle visible, then trap until flush
        drive(1'b1, IBad, 32'h118);
        tick();
        check_eq("bad_valid", {31'b0, bus.id_valid}, 32'd1);
        check_eq("bad_ill", {31'b0, bus.id_illegal}, 32'd1);
        check_eq("bad_imm", bus.id_imm, 32'h0);
        drive(1'b1, IAddi, 32'h11C);
        #1;
        check_eq("bad_ready", {31'b0, bus.instr_ready}, 32'd0);
        tick();
        check_eq("trap_valid", {31'b0, bus.id_valid}, 32'd0);
        check_eq("trap_ready", {31'b0, bus.instr_ready}, 32'd0);
        check_eq("trap_pc", bus.id_pc, 32'h118);
        tick();
        check_eq("trap_ready2", {31'b0, bus.instr_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        #1;
        check_eq("unflush_ready", {31'b0, bus.instr_ready}, 32'd1);
        check_eq("unflush_valid", {31'b0, bus.id_valid}, 32'd0);

        // Flush while holding with a new instruction presented and ex_ready=1
        drive(1'b1, IAddi, 32'h120);
        tick();
        check_eq("hold_pc", bus.id_pc, 32'h120);
        flush = 1'b1;
        drive(1'b1, ILui, 32'h124);
        #1;
        check_eq("flush_ready", {31'b0, bus.instr_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check_eq("flush_valid", {31'b0, bus.id_valid}, 32'd0);
        check_eq("flush_drop_pc", bus.id_pc, 32'h120);
        check_eq("flush_ready_after", {31'b0, bus.instr_ready}, 32'd1);

        // HOLD drains to IDLE when nothing new arrives
        drive(1'b1, IAddi, 32'h128);
        tick();
        check_eq("drain_hold", {31'b0, bus.id_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_eq("drain_idle", {31'b0, bus.id_valid}, 32'd0);

        // Reset pulse during HOLD
        drive(1'b1, ILui, 32'h12C);
        tick();
        check_eq("pre_rst_valid", {31'b0, bus.id_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_ready", {31'b0, bus.instr_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        check_eq("post_rst_valid", {31'b0, bus.id_valid}, 32'd0);
        check_eq("post_rst_imm", bus.id_imm, 32'h0);
        check_eq("post_rst_pc", bus.id_pc, 32'h0);
        check_eq("post_rst_rd", {27'b0, bus.id_rd}, 32'd0);
        check_eq("post_rst_ill", {31'b0, bus.id_illegal}, 32'd0);
        check_eq("post_rst_ready", {31'b0, bus.instr_ready}, 32'd1);
`ifdef DECODE_PERF_EN
        check_eq("post_rst_perf_acc", perf_accept, 32'd0);
        check_eq("post_rst_perf_stall", perf_stall, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
